// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states and
// the classifier that routes an op to the iterative multiply/divide unit.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SLL   = 4'b0110;
  localparam logic [3:0] OP_SRL   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;
  localparam logic [3:0] OP_DIV   = 4'b1110;
  localparam logic [3:0] OP_REM   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Everything from MUL upward runs through the radix-2 iterative unit.
  function automatic logic is_iter(input logic [3:0] op);
    return op >= OP_MUL;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Issue/writeback handshake bundle between the execute stage and the ALU.
interface seq_alu_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, op, input1, input2, out_ready,
    input  in_ready, out_valid, ALUResult, zero, busy
  );

  modport slave (
    input  in_valid, op, input1, input2, out_ready,
    output in_ready, out_valid, ALUResult, zero, busy
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Radix-2 shift-add multiplier / restoring divider. One step per cycle for
// WIDTH cycles; done is a combinational pulse during the last step, with the
// final (sign-corrected) result presented alongside it for the caller to latch.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);

  logic             active;
  logic [CW-1:0]    count;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc, mq, opb;
  logic             neg_q, neg_r;
  logic             sdiv;
  logic [WIDTH:0]   sum, shifted;
  logic [WIDTH-1:0] acc_nx, mq_nx;

  // Signed divide works on magnitudes; signs are restored at the end.
  assign sdiv = (op == OP_DIV) || (op == OP_REM);

  // One multiply (add then shift right) or divide (shift left then trial subtract) step.
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, (mq[0] ? opb : '0)};
    shifted = {acc, mq[WIDTH-1]};
    acc_nx  = acc;
    mq_nx   = mq;
    if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
      acc_nx = sum[WIDTH:1];
      mq_nx  = {sum[0], mq[WIDTH-1:1]};
    end else if (shifted >= {1'b0, opb}) begin
      acc_nx = WIDTH'(shifted - {1'b0, opb});
      mq_nx  = {mq[WIDTH-2:0], 1'b1};
    end else begin
      acc_nx = shifted[WIDTH-1:0];
      mq_nx  = {mq[WIDTH-2:0], 1'b0};
    end
  end

  // Final result selection with sign fixup, valid while done is high.
  always_comb begin
    result = '0;
    case (op_q)
      OP_MUL:           result = mq_nx;
      OP_MULHU:         result = acc_nx;
      OP_DIVU, OP_DIV:  result = neg_q ? -mq_nx : mq_nx;
      default:          result = neg_r ? -acc_nx : acc_nx;
    endcase
  end

  assign done = active && (count == CW'(WIDTH - 1));

  // Operand latch on start, then iterate until the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      count  <= '0;
      op_q   <= '0;
      acc    <= '0;
      mq     <= '0;
      opb    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      count  <= '0;
      op_q   <= op;
      acc    <= '0;
      mq     <= (sdiv && a[WIDTH-1]) ? -a : a;
      opb    <= (sdiv && b[WIDTH-1]) ? -b : b;
      // A zero divisor must leave the all-ones quotient untouched.
      neg_q  <= sdiv && (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
      neg_r  <= sdiv && a[WIDTH-1];
    end else if (active) begin
      acc   <= acc_nx;
      mq    <= mq_nx;
      count <= count + 1'b1;
      if (done) active <= 1'b0;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: single-cycle ops are registered straight into
// DONE, multiply/divide run through the iterative unit via BUSY.
//   state | meaning
//   IDLE  | ready to accept an operation
//   BUSY  | iterative multiply/divide in progress
//   DONE  | result held until the consumer takes it
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] alu_res, iter_res, res_q;
  logic             zero_q, accept, start, iter_done;
  logic [SHW-1:0]   shamt;

  assign shamt  = bus.input2[SHW-1:0];
  assign accept = bus.in_valid && (state == S_IDLE);
  assign start  = accept && is_iter(bus.op);

  // Single-cycle datapath.
  always_comb begin
    alu_res = '0;
    case (bus.op)
      OP_AND:  alu_res = bus.input1 & bus.input2;
      OP_OR:   alu_res = bus.input1 | bus.input2;
      OP_ADD:  alu_res = bus.input1 + bus.input2;
      OP_SUB:  alu_res = bus.input1 - bus.input2;
      OP_XOR:  alu_res = bus.input1 ^ bus.input2;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.input1) < $signed(bus.input2)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.input1 < bus.input2};
      OP_SLL:  alu_res = bus.input1 << shamt;
      OP_SRL:  alu_res = bus.input1 >> shamt;
      OP_SRA:  alu_res = $signed(bus.input1) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (bus.op),
    .a      (bus.input1),
    .b      (bus.input2),
    .done   (iter_done),
    .result (iter_res)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = is_iter(bus.op) ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        bus.busy = 1'b1;
        if (iter_done) state_nx = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Result register, loaded on a single-cycle accept or the final iterative step.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      zero_q <= 1'b1;
    end else if (accept && !is_iter(bus.op)) begin
      res_q  <= alu_res;
      zero_q <= (alu_res == '0);
    end else if ((state == S_BUSY) && iter_done) begin
      res_q  <= iter_res;
      zero_q <= (iter_res == '0);
    end
  end

  assign bus.ALUResult = res_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: WIDTH=32 directed vectors, backpressure and reset-abort
// sequences, then randomized sweeps at WIDTH=8 and WIDTH=64 against a model.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [3:0]  op;
  logic [63:0] a, b;
  int          sel;  // 0: WIDTH 32, 1: WIDTH 8, 2: WIDTH 64

  logic        ov, ir, zr, bz;
  logic [63:0] res;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) if32 ();
  seq_alu_if #(.WIDTH(8))  if8  ();
  seq_alu_if #(.WIDTH(64)) if64 ();

  seq_alu #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(if32));
  seq_alu #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(if8));
  seq_alu #(.WIDTH(64)) u64 (.clk(clk), .rst(rst), .bus(if64));

  assign if32.in_valid  = in_valid && (sel == 0);
  assign if32.out_ready = out_ready && (sel == 0);
  assign if32.op        = op;
  assign if32.input1    = a[31:0];
  assign if32.input2    = b[31:0];
  assign if8.in_valid   = in_valid && (sel == 1);
  assign if8.out_ready  = out_ready && (sel == 1);
  assign if8.op         = op;
  assign if8.input1     = a[7:0];
  assign if8.input2     = b[7:0];
  assign if64.in_valid  = in_valid && (sel == 2);
  assign if64.out_ready = out_ready && (sel == 2);
  assign if64.op        = op;
  assign if64.input1    = a;
  assign if64.input2    = b;

  always_comb begin
    ov = 1'b0; ir = 1'b0; zr = 1'b0; bz = 1'b0; res = '0;
    case (sel)
      0: begin ov = if32.out_valid; ir = if32.in_ready; zr = if32.zero; bz = if32.busy; res = {32'b0, if32.ALUResult}; end
      1: begin ov = if8.out_valid;  ir = if8.in_ready;  zr = if8.zero;  bz = if8.busy;  res = {56'b0, if8.ALUResult};  end
      default: begin ov = if64.out_valid; ir = if64.in_ready; zr = if64.zero; bz = if64.busy; res = if64.ALUResult; end
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] ref_alu(input logic [3:0] o, input logic [63:0] x_in,
                                          input logic [63:0] y_in, input int w);
    logic [63:0]        mask, x, y, minneg;
    logic signed [63:0] xs, ys;
    logic [127:0]       p;
    int                 sh;
    mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x      = x_in & mask;
    y      = y_in & mask;
    xs     = x[w-1] ? (x | ~mask) : x;
    ys     = y[w-1] ? (y | ~mask) : y;
    minneg = 64'd1 << (w - 1);
    sh     = int'(y & 64'(w - 1));
    p      = {64'b0, x} * {64'b0, y};
    case (o)
      OP_AND:   return x & y;
      OP_OR:    return x | y;
      OP_ADD:   return (x + y) & mask;
      OP_SUB:   return (x - y) & mask;
      OP_XOR:   return x ^ y;
      OP_SLT:   return (xs < ys) ? 64'd1 : 64'd0;
      OP_SLTU:  return (x < y) ? 64'd1 : 64'd0;
      OP_SLL:   return (x << sh) & mask;
      OP_SRL:   return x >> sh;
      OP_SRA:   return (xs >>> sh) & mask;
      OP_MUL:   return p[63:0] & mask;
      OP_MULHU: return 64'(p >> w) & mask;
      OP_DIVU:  return (y == 0) ? mask : x / y;
      OP_REMU:  return (y == 0) ? x : x % y;
      OP_DIV: begin
        if (y == 0) return mask;
        if (x == minneg && ys == -64'sd1) return minneg;
        return 64'(xs / ys) & mask;
      end
      default: begin
        if (y == 0) return x;
        if (x == minneg && ys == -64'sd1) return 64'd0;
        return 64'(xs % ys) & mask;
      end
    endcase
  endfunction

  // Issue one op, scramble inputs after acceptance, collect result and latency.
  task automatic do_op(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                       input int hold, output logic [63:0] r, output logic z,
                       output int lat, output int bcnt);
    int k;
    lat = 0; bcnt = 0; r = '0; z = 1'b0;
    @(negedge clk);
    k = 0;
    while (!ir && k < 200) begin @(negedge clk); k++; end
    if (!ir) begin chk("accept_timeout", 64'd0, 64'd1); return; end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bz) bcnt++;
      if (ov) begin lat = i; break; end
    end
    if (lat == 0) begin chk("result_timeout", 64'd0, 64'd1); return; end
    r = res; z = zr;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [3:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [63:0] r, x, y, e;
    logic        z;
    int          lat, bcnt, seen, w;
    logic [3:0]  o;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset_out_valid", {63'b0, ov}, 64'd0);
      chk("reset_busy", {63'b0, bz}, 64'd0);
      chk("reset_in_ready", {63'b0, ir}, 64'd1);
      chk("reset_result", res, 64'd0);
      chk("reset_zero", {63'b0, zr}, 64'd1);
    end
    sel = 0;

    vecs.push_back('{"add_wrap",   OP_ADD,   32'hFFFFFFFF, 32'h1,        32'h0});
    vecs.push_back('{"slt",        OP_SLT,   32'hFFFFFFFF, 32'h1,        32'h1});
    vecs.push_back('{"sltu",       OP_SLTU,  32'hFFFFFFFF, 32'h1,        32'h0});
    vecs.push_back('{"sra",        OP_SRA,   32'h80000000, 32'h4,        32'hF8000000});
    vecs.push_back('{"and",        OP_AND,   32'h0000F0F0, 32'h00000FF0, 32'h000000F0});
    vecs.push_back('{"or",         OP_OR,    32'h0000F0F0, 32'h00000FF0, 32'h0000FFF0});
    vecs.push_back('{"xor",        OP_XOR,   32'h0000F0F0, 32'h00000FF0, 32'h0000FF00});
    vecs.push_back('{"sub",        OP_SUB,   32'h5,        32'h7,        32'hFFFFFFFE});
    vecs.push_back('{"sll_mask",   OP_SLL,   32'h1,        32'h3F,       32'h80000000});
    vecs.push_back('{"srl_mask",   OP_SRL,   32'h80000000, 32'h21,       32'h40000000});
    vecs.push_back('{"mul",        OP_MUL,   32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE});
    vecs.push_back('{"mulhu",      OP_MULHU, 32'hFFFFFFFF, 32'h2,        32'h1});
    vecs.push_back('{"div_neg",    OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD});
    vecs.push_back('{"rem_neg",    OP_REM,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF});
    vecs.push_back('{"div_negdiv", OP_DIV,   32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD});
    vecs.push_back('{"rem_negdiv", OP_REM,   32'h7,        32'hFFFFFFFE, 32'h1});
    vecs.push_back('{"divu_zero",  OP_DIVU,  32'h7,        32'h0,        32'hFFFFFFFF});
    vecs.push_back('{"remu_zero",  OP_REMU,  32'h7,        32'h0,        32'h7});
    vecs.push_back('{"div_zero",   OP_DIV,   32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF});
    vecs.push_back('{"rem_zero",   OP_REM,   32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9});
    vecs.push_back('{"div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    vecs.push_back('{"rem_ovf",    OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'h0});
    vecs.push_back('{"divu",       OP_DIVU,  32'd100,      32'd7,        32'd14});
    vecs.push_back('{"remu",       OP_REMU,  32'd100,      32'd7,        32'd2});

    foreach (vecs[i]) begin
      do_op(vecs[i].o, {32'b0, vecs[i].x}, {32'b0, vecs[i].y}, i % 3, r, z, lat, bcnt);
      chk({vecs[i].name, "_result"}, r, {32'b0, vecs[i].exp});
      chk({vecs[i].name, "_zero"}, {63'b0, z}, {63'b0, vecs[i].exp == 32'h0});
      chk({vecs[i].name, "_latency"}, 64'(lat), (vecs[i].o >= OP_MUL) ? 64'd33 : 64'd1);
      chk({vecs[i].name, "_busy_cycles"}, 64'(bcnt), (vecs[i].o >= OP_MUL) ? 64'd32 : 64'd0);
    end

    // Backpressure: result held, no accept while DONE, IDLE right after release.
    @(negedge clk);
    op = OP_ADD; a = 64'd3; b = 64'd4; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); if (ov) seen = 1; end
    chk("bp_out_valid", 64'(seen), 64'd1);
    op = OP_SUB; a = 64'd100; b = 64'd1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_result_stable", res, 64'd7);
      chk("bp_zero_stable", {63'b0, zr}, 64'd0);
      chk("bp_in_ready_low", {63'b0, ir}, 64'd0);
      chk("bp_out_valid_held", {63'b0, ov}, 64'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_in_ready", {63'b0, ir}, 64'd1);
    chk("bp_release_out_valid", {63'b0, ov}, 64'd0);
    chk("bp_no_capture", res, 64'd7);

    // Reset during the fifth BUSY cycle of DIVU 100/7 aborts it.
    @(negedge clk);
    op = OP_DIVU; a = 64'd100; b = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_pre_busy", {63'b0, bz}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", {63'b0, ov}, 64'd0);
    chk("rst_busy", {63'b0, bz}, 64'd0);
    chk("rst_in_ready", {63'b0, ir}, 64'd1);
    chk("rst_result", res, 64'd0);
    chk("rst_zero", {63'b0, zr}, 64'd1);
    seen = 0;
    repeat (40) begin @(negedge clk); if (ov) seen++; end
    chk("rst_no_result", 64'(seen), 64'd0);

    // Randomized sweep at the other widths.
    for (int s = 1; s < 3; s++) begin
      sel = s;
      w = (s == 1) ? 8 : 64;
      for (int n = 0; n < 40; n++) begin
        o = 4'($urandom_range(0, 15));
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        case ($urandom_range(0, 7))
          0: y = '0;
          1: begin x = 64'd1 << (w - 1); y = '1; end
          2: y = 64'($urandom_range(1, 5));
          default: ;
        endcase
        if (w == 8) begin x = x & 64'hFF; y = y & 64'hFF; end
        e = ref_alu(o, x, y, w);
        do_op(o, x, y, $urandom_range(0, 3), r, z, lat, bcnt);
        chk($sformatf("w%0d_op%0d_result", w, o), r, e);
        chk($sformatf("w%0d_op%0d_zero", w, o), {63'b0, z}, {63'b0, e == 64'd0});
        chk($sformatf("w%0d_op%0d_latency", w, o), 64'(lat), (o >= OP_MUL) ? 64'(w + 1) : 64'd1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
